pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// It forwards ALU operands from M/W, stalls on load-use hazards, flushes on
// taken branches, freezes the whole pipe while data memory is busy, and
// holds the pipe for HOLD_CYCLES cycles after reset. It also keeps
// saturating stall/flush performance counters.
//
// Memory handshake: dmem_req marks an M-stage access in flight. dmem_ready
// completes it in the same cycle. A cycle with dmem_req=1 and dmem_ready=0
// freezes F/D/E/M and bubbles W until a cycle with dmem_ready=1 arrives.
// dmem_req=1 with dmem_ready=1 completes at once and causes no stall.
//
// HOLD_CYCLES must be at least 1.
module pipeline_ctrl #(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    HOLD     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t        state, state_next;
  logic [HW-1:0] hold_cnt;
  logic          hold_last;
  logic          lw_stall;
  logic          mem_stall;
  logic [1:0]    fwd_a, fwd_b;

  // Operand source for one ALU input. M wins over W, and x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RD_M != 5'd0) && (RD_M == rs))      return 2'b10;
    else if (RegWriteW && (RD_W != 5'd0) && (RD_W == rs)) return 2'b01;
    else                                                  return 2'b00;
  endfunction

  assign hold_last = (hold_cnt == HOLD_LAST);
  assign lw_stall  = ResultSrcE0 && (RD_E != 5'd0) &&
                     ((RS1_D == RD_E) || (RS2_D == RD_E));
  assign mem_stall = dmem_req && !dmem_ready;
  assign fwd_a     = fwd_sel(RS1_E);
  assign fwd_b     = fwd_sel(RS2_E);
  assign state_o   = state;

  // State register; reset always restarts HOLD.
  always_ff @(posedge clk) begin
    if (rst) state <= HOLD;
    else     state <= state_next;
  end

  // Post-reset hold counter. It is cleared whenever it is not counting, so
  // every entry to HOLD starts a full count.
  always_ff @(posedge clk) begin
    if (rst)                           hold_cnt <= '0;
    else if (state == HOLD && !hold_last) hold_cnt <= hold_cnt + 1'b1;
    else                               hold_cnt <= '0;
  end

  // Next state and control outputs. A memory stall takes over the outputs in
  // the same cycle it is seen, and it masks load-use and branch effects.
  always_comb begin
    state_next = state;
    ForwardAE  = 2'b00;
    ForwardBE  = 2'b00;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;
    case (state)
      HOLD: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushW = 1'b1;
        if (hold_last) state_next = RUN;
      end
      RUN, MEM_WAIT: begin
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        if ((state == RUN && mem_stall) || (state == MEM_WAIT && !dmem_ready)) begin
          StallF     = 1'b1;
          StallD     = 1'b1;
          StallE     = 1'b1;
          StallM     = 1'b1;
          FlushW     = 1'b1;
          state_next = MEM_WAIT;
        end else begin
          StallF     = lw_stall;
          StallD     = lw_stall;
          FlushD     = PCSrcE;
          FlushE     = lw_stall || PCSrcE;
          state_next = RUN;
        end
      end
      default: state_next = HOLD;
    endcase
  end

  // Saturating performance counters. Cycles spent in HOLD are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && state != HOLD && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (FlushE && state != HOLD && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl. It uses a table of single-cycle RUN vectors
// plus hand-written sequences for reset/HOLD, the memory wait, reset aborts
// and counter saturation. A second instance with CNT_W=4 shares the same
// inputs so that it can show saturation.
module tb_pipeline_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, dmem_req, dmem_ready;

  logic [1:0]  ForwardAE, ForwardBE, state_o;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0]  fa2, fb2, state2;
  logic        sf2, sd2, se2, sm2, fd2, fe2, fw2;
  logic [3:0]  stall_cnt2, flush_cnt2;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_o(state_o)
  );

  pipeline_ctrl #(.HOLD_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .ForwardAE(fa2), .ForwardBE(fb2),
    .StallF(sf2), .StallD(sd2), .StallE(se2), .StallM(sm2),
    .FlushD(fd2), .FlushE(fe2), .FlushW(fw2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2), .state_o(state2)
  );

  // Output bit order: {FA[1:0], FB[1:0], StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [10:0] outs;
  assign outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  localparam logic [10:0] HOLD_O = 11'b00_00_1000_111;
  localparam logic [10:0] MEMW_O = 11'b00_00_1111_001;
  localparam logic [10:0] IDLE_O = 11'b00_00_0000_000;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  typedef struct {
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        rwm, rww, ld, br;
    logic [10:0] exp_o;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
                              input logic rwm, rww, ld, br, input logic [10:0] exp_o);
    vec_t v;
    v.rs1_d = rs1_d; v.rs2_d = rs2_d; v.rs1_e = rs1_e; v.rs2_e = rs2_e;
    v.rd_e = rd_e; v.rd_m = rd_m; v.rd_w = rd_w;
    v.rwm = rwm; v.rww = rww; v.ld = ld; v.br = br; v.exp_o = exp_o;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    RS1_D = v.rs1_d; RS2_D = v.rs2_d; RS1_E = v.rs1_e; RS2_E = v.rs2_e;
    RD_E = v.rd_e; RD_M = v.rd_m; RD_W = v.rd_w;
    RegWriteM = v.rwm; RegWriteW = v.rww; ResultSrcE0 = v.ld; PCSrcE = v.br;
  endtask

  vec_t vecs[12];

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0,0,0,0,0,0,0, 0,0,0,0, IDLE_O);
    vecs[1]  = mk(0,0,5,0,0,5,5, 1,1,0,0, 11'b10_00_0000_000);
    vecs[2]  = mk(0,0,5,0,0,0,5, 1,1,0,0, 11'b01_00_0000_000);
    vecs[3]  = mk(0,0,3,5,0,5,0, 1,0,0,0, 11'b00_10_0000_000);
    vecs[4]  = mk(0,0,9,9,0,9,9, 0,1,0,0, 11'b01_01_0000_000);
    vecs[5]  = mk(0,0,0,0,0,0,0, 1,1,0,0, IDLE_O);
    vecs[6]  = mk(0,7,0,0,7,0,0, 0,0,1,0, 11'b00_00_1100_010);
    vecs[7]  = mk(0,7,0,0,7,0,0, 0,0,1,1, 11'b00_00_1100_110);
    vecs[8]  = mk(0,0,0,0,0,0,0, 0,0,0,1, 11'b00_00_0000_110);
    vecs[9]  = mk(0,0,0,0,0,0,0, 0,0,1,0, IDLE_O);
    vecs[10] = mk(4,0,0,0,4,0,0, 0,0,1,0, 11'b00_00_1100_010);
    vecs[11] = mk(4,0,0,0,4,0,0, 0,0,0,0, IDLE_O);

    clear_inputs();
    tick();

    // ---- reset then HOLD for two cycles, with forwarding bait present ----
    rst = 1;
    tick();
    rst = 0;
    RegWriteM = 1; RD_M = 5; RS1_E = 5;
    @(negedge clk);
    chk("hold0_state", 32'(state_o), 32'd0);
    chk("hold0_outs", 32'(outs), 32'(HOLD_O));
    chk("hold0_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("hold0_flush_cnt", 32'(flush_cnt), 32'd0);
    tick();
    @(negedge clk);
    chk("hold1_state", 32'(state_o), 32'd0);
    chk("hold1_outs", 32'(outs), 32'(HOLD_O));
    tick();
    clear_inputs();
    @(negedge clk);
    chk("run_entry_state", 32'(state_o), 32'd1);
    chk("run_entry_outs", 32'(outs), 32'(IDLE_O));
    tick();

    // ---- table-driven RUN vectors ----
    for (int i = 0; i < 12; i++) begin
      drive_vec(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp_o));
      chk($sformatf("vec%0d_state", i), 32'(state_o), 32'd1);
      exp_stall += int'(vecs[i].exp_o[6]);
      exp_flush += int'(vecs[i].exp_o[1]);
      tick();
    end
    clear_inputs();
    chk("vec_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    chk("vec_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

    // ---- memory wait: three not-ready cycles, then ready ----
    dmem_req = 1; dmem_ready = 0;
    @(negedge clk);
    chk("mw_entry_outs", 32'(outs), 32'(MEMW_O));
    chk("mw_entry_state", 32'(state_o), 32'd1);
    tick();
    ResultSrcE0 = 1; RD_E = 7; RS2_D = 7; PCSrcE = 1;
    @(negedge clk);
    chk("mw1_masked_outs", 32'(outs), 32'(MEMW_O));
    chk("mw1_state", 32'(state_o), 32'd2);
    tick();
    ResultSrcE0 = 0; RD_E = 0; RS2_D = 0; PCSrcE = 0;
    RegWriteM = 1; RD_M = 5; RS1_E = 5;
    @(negedge clk);
    chk("mw2_fwd_outs", 32'(outs), 32'(11'b10_00_1111_001));
    chk("mw2_state", 32'(state_o), 32'd2);
    tick();
    RegWriteM = 0; RD_M = 0; RS1_E = 0;
    dmem_ready = 1;
    @(negedge clk);
    chk("mw_ready_outs", 32'(outs), 32'(IDLE_O));
    tick();
    clear_inputs();
    exp_stall += 3;
    chk("mw_exit_state", 32'(state_o), 32'd1);
    chk("mw_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    chk("mw_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

    // ---- req and ready in the same cycle: no stall ----
    dmem_req = 1; dmem_ready = 1;
    @(negedge clk);
    chk("fast_mem_outs", 32'(outs), 32'(IDLE_O));
    tick();
    clear_inputs();
    chk("fast_mem_state", 32'(state_o), 32'd1);
    chk("fast_mem_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    // ---- reset during MEM_WAIT ----
    dmem_req = 1; dmem_ready = 0;
    tick();
    chk("pre_rst_state", 32'(state_o), 32'd2);
    rst = 1;
    tick();
    rst = 0;
    clear_inputs();
    chk("rst_mw_state", 32'(state_o), 32'd0);
    chk("rst_mw_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_mw_flush_cnt", 32'(flush_cnt), 32'd0);

    // ---- reset in the middle of HOLD restarts a full count ----
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_hold_h0", 32'(state_o), 32'd0);
    tick();
    chk("rst_hold_h1", 32'(state_o), 32'd0);
    tick();
    chk("rst_hold_run", 32'(state_o), 32'd1);

    // ---- counter saturation: load-use hazard held for 20 cycles ----
    rst = 1;
    tick();
    rst = 0;
    tick();
    tick();
    ResultSrcE0 = 1; RD_E = 7; RS2_D = 7;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 13) chk("sat_cnt4_at14", 32'(stall_cnt2), 32'd14);
    end
    clear_inputs();
    chk("sat_cnt4_stall", 32'(stall_cnt2), 32'd15);
    chk("sat_cnt4_flush", 32'(flush_cnt2), 32'd15);
    chk("sat_cnt16_stall", 32'(stall_cnt), 32'd20);
    chk("sat_cnt16_flush", 32'(flush_cnt), 32'd20);

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
